// File: rtl/instr_encoder_loader.sv
// Turns field-level instruction requests into 32-bit ARM words for the supported subset.
// Each legal word is written to the next instruction memory address, starting at BASE_ADDR.
module instr_encoder_loader #(
  parameter int ADDR_WIDTH = 9,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  START,
  input  logic                  ReqValid,
  output logic                  ReqReady,
  input  logic [1:0]            ReqKind,
  input  logic [3:0]            ReqCond,
  input  logic [2:0]            ReqOp,
  input  logic                  ReqS,
  input  logic                  ReqImm,
  input  logic                  ReqU,
  input  logic [3:0]            ReqRd,
  input  logic [3:0]            ReqRn,
  input  logic [11:0]           ReqSrc2,
  input  logic [23:0]           ReqImm24,
  output logic                  IM_WE,
  output logic [ADDR_WIDTH-1:0] IM_ADDR,
  output logic [31:0]           IM_WDATA,
  output logic [ADDR_WIDTH:0]   WordCount,
  output logic                  Full,
  output logic                  Err
);

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_WRITE = 1'b1;

  localparam logic [ADDR_WIDTH:0]   CAPACITY = (ADDR_WIDTH+1)'((1 << ADDR_WIDTH) - BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] PTR_MAX  = '1;

  function automatic logic [3:0] dp_cmd(input logic [2:0] op);
    logic [3:0] cmd;
    case (op)
      3'd0:    cmd = 4'b0100;
      3'd1:    cmd = 4'b0010;
      3'd2:    cmd = 4'b0000;
      3'd3:    cmd = 4'b1100;
      3'd4:    cmd = 4'b1010;
      3'd5:    cmd = 4'b1011;
      default: cmd = 4'b0000;
    endcase
    return cmd;
  endfunction

  function automatic logic is_illegal(input logic [1:0] kind, input logic [2:0] op);
    return (kind == 2'd3) ||
           (kind == 2'd0 && op > 3'd5) ||
           (kind == 2'd1 && op[2:1] != 2'b00);
  endfunction

  function automatic logic [31:0] encode(
    input logic [1:0]  kind,
    input logic [3:0]  cond,
    input logic [2:0]  op,
    input logic        s,
    input logic        imm,
    input logic        u,
    input logic [3:0]  rd,
    input logic [3:0]  rn,
    input logic [11:0] src2,
    input logic [23:0] imm24
  );
    logic        compare_op;
    logic [31:0] word;
    // CMP/CMN only set flags: S is forced on and the destination field is zeroed.
    compare_op = (op == 3'd4) || (op == 3'd5);
    case (kind)
      2'd0:    word = {cond, 2'b00, imm, dp_cmd(op), s | compare_op, rn,
                       compare_op ? 4'd0 : rd, src2};
      2'd1:    word = {cond, 2'b01, 1'b0, 1'b1, u, 1'b0, 1'b0, op[0], rn, rd, src2};
      default: word = {cond, 4'b1010, imm24};
    endcase
    return word;
  endfunction

  logic                  state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  full;
  logic                  accept;

  assign full     = (cnt_q == CAPACITY);
  assign ReqReady = (state_q == ST_IDLE) && !full && !START;
  assign accept   = ReqValid && ReqReady;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    wdata_d = wdata_q;
    if (START) begin
      state_d = ST_IDLE;
      ptr_d   = BASE;
      cnt_d   = '0;
      err_d   = 1'b0;
      wdata_d = '0;
    end else if (state_q == ST_WRITE) begin
      // The pointer saturates at the top of memory; Full blocks any further request.
      state_d = ST_IDLE;
      cnt_d   = cnt_q + 1'b1;
      if (ptr_q != PTR_MAX) ptr_d = ptr_q + 1'b1;
    end else if (accept) begin
      if (is_illegal(ReqKind, ReqOp)) begin
        err_d = 1'b1;
      end else begin
        wdata_d = encode(ReqKind, ReqCond, ReqOp, ReqS, ReqImm, ReqU,
                         ReqRd, ReqRn, ReqSrc2, ReqImm24);
        state_d = ST_WRITE;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      ptr_q   <= BASE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      wdata_q <= wdata_d;
    end
  end

  assign IM_WE     = (state_q == ST_WRITE);
  assign IM_ADDR   = ptr_q;
  assign IM_WDATA  = wdata_q;
  assign WordCount = cnt_q;
  assign Full      = full;
  assign Err       = err_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: directed literal cases, then random requests checked
// every cycle against a transaction-level model (pending word, word count, sticky error).
module tb_instr_encoder_loader;
  localparam int AW   = 2;
  localparam int BASE = 0;
  localparam int CAP  = (1 << AW) - BASE;

  logic          CLK = 1'b0;
  logic          RESET, START, ReqValid;
  logic          ReqReady;
  logic [1:0]    ReqKind;
  logic [3:0]    ReqCond;
  logic [2:0]    ReqOp;
  logic          ReqS, ReqImm, ReqU;
  logic [3:0]    ReqRd, ReqRn;
  logic [11:0]   ReqSrc2;
  logic [23:0]   ReqImm24;
  logic          IM_WE;
  logic [AW-1:0] IM_ADDR;
  logic [31:0]   IM_WDATA;
  logic [AW:0]   WordCount;
  logic          Full, Err;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  // Model state: a word waiting to be written, words written, sticky error, last word.
  bit          m_pend;
  int          m_cnt;
  bit          m_err;
  logic [31:0] m_word;

  instr_encoder_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .ReqValid(ReqValid), .ReqReady(ReqReady),
    .ReqKind(ReqKind), .ReqCond(ReqCond), .ReqOp(ReqOp), .ReqS(ReqS), .ReqImm(ReqImm),
    .ReqU(ReqU), .ReqRd(ReqRd), .ReqRn(ReqRn), .ReqSrc2(ReqSrc2), .ReqImm24(ReqImm24),
    .IM_WE(IM_WE), .IM_ADDR(IM_ADDR), .IM_WDATA(IM_WDATA), .WordCount(WordCount),
    .Full(Full), .Err(Err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit model_illegal(input int kind, input int op);
    return kind == 3 || (kind == 0 && op > 5) || (kind == 1 && op > 1);
  endfunction

  function automatic logic [31:0] model_enc(input int kind, input int cond, input int op,
      input int s, input int imm, input int u, input int rd, input int rn,
      input int src2, input int imm24);
    int cmd_tab[6] = '{4, 2, 0, 12, 10, 11};
    int unsigned w;
    bit flags_only;
    flags_only = (kind == 0) && (op == 4 || op == 5);
    if (kind == 0)
      w = (cond << 28) + (imm << 25) + (cmd_tab[op] << 21) + ((flags_only ? 1 : s) << 20)
          + (rn << 16) + ((flags_only ? 0 : rd) << 12) + src2;
    else if (kind == 1)
      w = (cond << 28) + (1 << 26) + (1 << 24) + (u << 23) + ((op % 2) << 20)
          + (rn << 16) + (rd << 12) + src2;
    else
      w = (cond << 28) + (10 << 24) + imm24;
    return w;
  endfunction

  always @(posedge CLK) begin
    if (RESET || START) begin
      m_pend <= 1'b0;
      m_cnt  <= 0;
      m_err  <= 1'b0;
      m_word <= '0;
    end else if (m_pend) begin
      m_pend <= 1'b0;
      m_cnt  <= m_cnt + 1;
    end else if (ReqValid && m_cnt != CAP) begin
      if (model_illegal(ReqKind, ReqOp)) begin
        m_err <= 1'b1;
      end else begin
        m_word <= model_enc(ReqKind, ReqCond, ReqOp, ReqS, ReqImm, ReqU,
                            ReqRd, ReqRn, ReqSrc2, ReqImm24);
        m_pend <= 1'b1;
      end
    end
  end

  always @(negedge CLK) begin
    if (cmp_en) begin
      chk("m_we", IM_WE, m_pend);
      if (m_pend) chk("m_addr", IM_ADDR, BASE + m_cnt);
      chk("m_wdata", IM_WDATA, m_word);
      chk("m_count", WordCount, m_cnt);
      chk("m_full", Full, m_cnt == CAP);
      chk("m_err", Err, m_err);
      chk("m_ready", ReqReady, !m_pend && m_cnt != CAP && !START);
    end
  end

  task automatic issue(input int k, input int c, input int op, input int s, input int im,
                       input int u, input int rd, input int rn, input int src2, input int i24);
    ReqKind = 2'(k); ReqCond = 4'(c); ReqOp = 3'(op); ReqS = 1'(s); ReqImm = 1'(im);
    ReqU = 1'(u); ReqRd = 4'(rd); ReqRn = 4'(rn); ReqSrc2 = 12'(src2); ReqImm24 = 24'(i24);
    ReqValid = 1'b1;
    @(posedge CLK); #1;
    ReqValid = 1'b0;
  endtask

  task automatic expect_write(input string nm, input logic [31:0] w, input int addr);
    chk({nm, "_we"}, IM_WE, 1'b1);
    chk({nm, "_addr"}, IM_ADDR, addr);
    chk({nm, "_data"}, IM_WDATA, w);
    @(posedge CLK); #1;
    chk({nm, "_we_off"}, IM_WE, 1'b0);
  endtask

  task automatic start_pulse();
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; START = 1'b0; ReqValid = 1'b0;
    ReqKind = '0; ReqCond = '0; ReqOp = '0; ReqS = 1'b0; ReqImm = 1'b0; ReqU = 1'b0;
    ReqRd = '0; ReqRn = '0; ReqSrc2 = '0; ReqImm24 = '0;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
    cmp_en = 1'b1;
    chk("rst_we", IM_WE, 1'b0);
    chk("rst_addr", IM_ADDR, BASE);
    chk("rst_wdata", IM_WDATA, 32'h0);
    chk("rst_count", WordCount, 0);
    chk("rst_err", Err, 1'b0);
    chk("rst_ready", ReqReady, 1'b1);

    issue(0, 14, 0, 0, 1, 0, 1, 2, 5, 0);
    expect_write("add", 32'hE2821005, 0);

    start_pulse();
    issue(0, 14, 1, 1, 0, 0, 3, 3, 4, 0);
    expect_write("sub", 32'hE0533004, 0);
    issue(0, 14, 4, 0, 1, 0, 7, 0, 0, 0);
    expect_write("cmp", 32'hE3500000, 1);
    issue(1, 14, 0, 0, 0, 1, 1, 2, 8, 0);
    expect_write("str", 32'hE5821008, 2);
    issue(1, 14, 1, 0, 0, 0, 1, 2, 4, 0);
    expect_write("ldr", 32'hE5121004, 3);
    chk("full_flag", Full, 1'b1);
    chk("full_ready", ReqReady, 1'b0);
    chk("full_count", WordCount, 4);
    ReqValid = 1'b1; ReqKind = 2'd2;
    repeat (3) begin
      @(posedge CLK); #1;
      chk("stall_we", IM_WE, 1'b0);
      chk("stall_count", WordCount, 4);
    end
    ReqValid = 1'b0;

    start_pulse();
    issue(2, 1, 0, 0, 0, 0, 0, 0, 0, 24'hFFFFFD);
    expect_write("br", 32'h1AFFFFFD, 0);
    issue(3, 14, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("ill_err", Err, 1'b1);
    chk("ill_we", IM_WE, 1'b0);
    chk("ill_count", WordCount, 1);
    issue(0, 14, 0, 0, 1, 0, 1, 2, 5, 0);
    expect_write("after_ill", 32'hE2821005, 1);

    start_pulse();
    chk("start_err_clr", Err, 1'b0);
    issue(0, 14, 6, 0, 0, 0, 0, 0, 0, 0);
    chk("dp_op6_err", Err, 1'b1);
    start_pulse();
    issue(1, 14, 2, 0, 0, 0, 0, 0, 0, 0);
    chk("mem_op2_err", Err, 1'b1);
    chk("mem_op2_count", WordCount, 0);

    issue(0, 14, 3, 0, 0, 0, 4, 5, 6, 0);
    chk("abort_we_before", IM_WE, 1'b1);
    start_pulse();
    chk("abort_we", IM_WE, 1'b0);
    chk("abort_count", WordCount, 0);
    chk("abort_err", Err, 1'b0);
    issue(0, 14, 0, 0, 1, 0, 1, 2, 5, 0);
    expect_write("post_abort", 32'hE2821005, BASE);

    repeat (3000) begin
      ReqValid = ($urandom_range(0, 3) != 0);
      ReqKind  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      ReqCond  = 4'($urandom);
      ReqOp    = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'($urandom_range(0, 5));
      if (ReqKind == 2'd1 && $urandom_range(0, 5) != 0) ReqOp = 3'($urandom_range(0, 1));
      ReqS     = 1'($urandom);
      ReqImm   = 1'($urandom);
      ReqU     = 1'($urandom);
      ReqRd    = 4'($urandom);
      ReqRn    = 4'($urandom);
      ReqSrc2  = 12'($urandom);
      ReqImm24 = 24'($urandom);
      START    = ($urandom_range(0, 24) == 0);
      RESET    = ($urandom_range(0, 199) == 0);
      @(posedge CLK); #1;
    end
    RESET = 1'b0; START = 1'b0; ReqValid = 1'b0;
    @(posedge CLK); #1;
    @(negedge CLK); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
